// File: rtl/spi_exe_pkg.sv
// spi_exe_pkg: shared SPI execution-unit constants, result record and one-hot decode helper.
package spi_exe_pkg;
    localparam int SPI_BITS = 8;
    typedef struct packed {
        logic                err;
        logic [SPI_BITS-1:0] vec;
    } onehot_res_t;
    function automatic logic [SPI_BITS-1:0] onehot_decode(input logic [SPI_BITS-1:0] idx);
        onehot_decode = '0;
        for (int i = 0; i < SPI_BITS; i++) onehot_decode[i] = (idx == SPI_BITS'(i));
    endfunction
endpackage

// File: rtl/vr_pipe_stage.sv
// vr_pipe_stage: one valid/ready register slice; accepts when empty or draining in the same cycle.
module vr_pipe_stage #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    always_comb begin
        o_ready = !valid_q || i_ready;
        valid_d = o_ready ? i_valid : valid_q;
        data_d  = (o_ready && i_valid) ? i_data : data_q;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
    assign o_valid = valid_q;
    assign o_data  = data_q;
endmodule

// File: rtl/binary_to_onehot_pipe.sv
// binary_to_onehot_pipe: two-stage registered binary-to-one-hot decoder with range check and enable mask.
// Define BINARY_TO_ONEHOT_ERRCNT_EN to add the saturating out-of-range counter o_err_cnt.
module binary_to_onehot_pipe
    import spi_exe_pkg::*;
#(
    parameter int BITS = SPI_BITS,
    parameter int CNTW = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [BITS-1:0] i_argA,
    input  logic [BITS-1:0] i_argB,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [BITS-1:0] o_result,
    output logic            o_err
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
    ,
    output logic [CNTW-1:0] o_err_cnt
`endif
);
    localparam logic [BITS:0] LIMIT = (BITS+1)'(BITS);
    logic              in_oor;
    logic [2*BITS:0]   s1_in, s1_data;
    logic              s1_valid, s2_ready;
    logic [BITS-1:0]   s1_idx, s1_mask;
    logic              s1_oor;
    onehot_res_t       res_d, res_q;
    always_comb begin
        in_oor  = {1'b0, i_argA} >= LIMIT;
        s1_in   = {in_oor, i_argB, i_argA};
        s1_idx  = s1_data[BITS-1:0];
        s1_mask = s1_data[2*BITS-1:BITS];
        s1_oor  = s1_data[2*BITS];
        res_d.err = s1_oor;
        res_d.vec = s1_oor ? '0 : (onehot_decode(SPI_BITS'(s1_idx)) & SPI_BITS'(s1_mask));
    end
    vr_pipe_stage #(.W(2*BITS+1)) u_s1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(s1_in),
        .o_valid(s1_valid), .i_ready(s2_ready), .o_data(s1_data)
    );
    vr_pipe_stage #(.W($bits(onehot_res_t))) u_s2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(s1_valid), .o_ready(s2_ready), .i_data(res_d),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(res_q)
    );
    assign o_result = BITS'(res_q.vec);
    assign o_err    = res_q.err;
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
    // Counts at stage-1 acceptance so stalled operands are counted exactly once.
    logic [CNTW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (i_valid && o_ready && in_oor && cnt_q != '1) ? cnt_q + CNTW'(1) : cnt_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign o_err_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_binary_to_onehot_pipe.sv
// tb_binary_to_onehot_pipe: directed self-checking bench; drives and samples on the falling edge.
module tb_binary_to_onehot_pipe;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_ready = 1'b0;
    logic [7:0] i_argA = '0;
    logic [7:0] i_argB = '0;
    logic       o_ready, o_valid, o_err;
    logic [7:0] o_result;
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
    logic [7:0] o_err_cnt;
`endif
    int n_chk = 0;
    int n_err = 0;
    logic [7:0] exp_stream [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    binary_to_onehot_pipe #(.BITS(8), .CNTW(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_argA(i_argA), .i_argB(i_argB),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_err(o_err)
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
        , .o_err_cnt(o_err_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic v, input logic [7:0] a, input logic [7:0] b);
        i_valid = v;
        i_argA  = a;
        i_argB  = b;
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    initial begin
        #3;
        check("rst_valid", o_valid, 0);
        check("rst_result", o_result, 8'h00);
        check("rst_err", o_err, 0);
        check("rst_ready", o_ready, 1);
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
        check("rst_cnt", o_err_cnt, 0);
`endif
        tick();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 1) check("lat_valid", o_valid, 0);
            if (c >= 2) begin
                check("str_valid", o_valid, 1);
                check("str_result", o_result, exp_stream[c-2]);
                check("str_err", o_err, 0);
            end
            if (c < 8) send(1'b1, 8'(c), 8'hFF);
            else send(1'b0, 8'h00, 8'h00);
            tick();
        end
        check("idle_valid", o_valid, 0);
        check("idle_hold", o_result, 8'h80);
        send(1'b1, 8'd8, 8'hFF);
        tick();
        send(1'b1, 8'd200, 8'hFF);
        tick();
        check("oor8_valid", o_valid, 1);
        check("oor8_result", o_result, 8'h00);
        check("oor8_err", o_err, 1);
        send(1'b0, 8'h00, 8'h00);
        tick();
        check("oor200_valid", o_valid, 1);
        check("oor200_result", o_result, 8'h00);
        check("oor200_err", o_err, 1);
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
        check("oor_cnt", o_err_cnt, 2);
`endif
        send(1'b1, 8'd3, 8'hF7);
        tick();
        send(1'b1, 8'd5, 8'hF7);
        tick();
        check("mask_off_result", o_result, 8'h00);
        check("mask_off_err", o_err, 0);
        send(1'b0, 8'h00, 8'h00);
        tick();
        check("mask_on_result", o_result, 8'h20);
        check("mask_on_err", o_err, 0);
        tick();
        i_ready = 1'b0;
        send(1'b1, 8'd1, 8'hFF);
        #1 check("bp_ready0", o_ready, 1);
        tick();
        send(1'b1, 8'd2, 8'hFF);
        check("bp_ready1", o_ready, 1);
        tick();
        send(1'b1, 8'd4, 8'hFF);
        check("bp_ready2", o_ready, 0);
        check("bp_valid2", o_valid, 1);
        check("bp_result2", o_result, 8'h02);
        tick();
        check("bp_ready3", o_ready, 0);
        check("bp_result3", o_result, 8'h02);
        i_ready = 1'b1;
        #1 check("bp_ready_comb", o_ready, 1);
        tick();
        send(1'b0, 8'h00, 8'h00);
        check("bp_drain1_valid", o_valid, 1);
        check("bp_drain1", o_result, 8'h04);
        tick();
        check("bp_drain2_valid", o_valid, 1);
        check("bp_drain2", o_result, 8'h10);
        tick();
        check("bp_empty", o_valid, 0);
        i_ready = 1'b0;
        send(1'b1, 8'd6, 8'hFF);
        tick();
        send(1'b1, 8'd7, 8'hFF);
        tick();
        check("mr_valid", o_valid, 1);
        check("mr_result", o_result, 8'h40);
        check("mr_ready", o_ready, 0);
        i_rst_n = 1'b0;
        send(1'b0, 8'h00, 8'h00);
        #1;
        check("mr_async_valid", o_valid, 0);
        check("mr_async_result", o_result, 8'h00);
        check("mr_async_ready", o_ready, 1);
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
        check("mr_cnt", o_err_cnt, 0);
`endif
        tick();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mr_no_stale", o_valid, 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/binary_to_onehot_pipe.md
# binary_to_onehot_pipe

Registered binary-to-one-hot decoder for the SPI execution unit, the inverse of the one-hot-to-binary converter already in the datapath. It accepts a binary bit index on `i_argA` with a valid/ready handshake, range-checks it against `BITS`, and returns a `BITS`-wide one-hot vector two cycles later. The unit supports full back-pressure and accepts one operand per cycle. It drives the bit-select and mask-generation paths of the execution unit.

## Interface
- `BITS`, 8: width of `o_result` and of `i_argA`; legal indices are 0..BITS-1.
- `CNTW`, 8: width of the error counter (used only when `BINARY_TO_ONEHOT_ERRCNT_EN` is defined).

Ports:
- `i_clk`  in  1  single clock; all state on rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low; polarity and synchronicity fixed.
- `i_valid`  in  1  upstream operand valid.
- `o_ready`  out  1  unit can accept an operand this cycle.
- `i_argA`  in  BITS  binary index, unsigned.
- `i_argB`  in  BITS  enable mask; the result is ANDed with it.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  downstream accepts result.
- `o_result`  out  BITS  one-hot, or zero, result.
- `o_err`  out  1  index was out of range; qualified by `o_valid`.
- `o_err_cnt`  out  CNTW  saturating count of out-of-range operands (macro only).

## Operation
- Accept: an operand transfers on a rising edge when `i_valid && o_ready`.
- Stage 1 registers:
  - `idx = i_argA`
  - `mask = i_argB`
  - `oor = (i_argA >= BITS)`, compared at full BITS width with no truncation.
- Stage 2 registers:
  - `o_result = oor ? 0 : ((1 << idx) & mask)`
  - `o_err = oor`
- A masked-off in-range bit gives `o_result = 0` with `o_err = 0`.
- The result transfers when `o_valid && i_ready`.
- `o_ready = !s1_valid || !o_valid || i_ready`. Stage 1 may advance into stage 2 when stage 2 is empty or is being drained in the same cycle.
- With `o_valid=1` and `i_ready=0`, stage 2 holds its value and `o_result`/`o_err` stay stable. Stage 1 holds one more operand, then `o_ready` drops.
- Simultaneous accept and drain keeps full throughput with no bubble.
- Reset mid-operation discards both stages immediately; no partial result is emitted.
- Error counter: increments by 1 when an out-of-range operand is accepted into stage 1, and saturates at 2^CNTW-1.

## Timing
- Reset values:
  - `o_valid=0`
  - `o_result=0`
  - `o_err=0`
  - `o_err_cnt=0`
  - internal `s1_valid=0`, so `o_ready=1`
- Latency: operand accepted at edge N produces `o_valid=1` after edge N+1 with no stall. The result is visible in the cycle following N+1.
- Throughput: 1 operand per cycle while `i_ready=1`.
- Capacity: 2 operands in flight. `o_ready` is combinational from `i_ready` and internal state only, never from `i_valid`.
- `o_result`/`o_err` change only on an edge where stage 2 loads. Content is undefined-free: they retain their last value when `o_valid=0`.

## Configuration
- `BINARY_TO_ONEHOT_ERRCNT_EN` defined: `o_err_cnt` port and `CNTW`-bit saturating counter present. The counter is cleared only by reset.
- Not defined: port and counter absent; no other behaviour changes.

## Structure
- Shared package `spi_exe_pkg` holds:
  - default `BITS` constant
  - `function automatic` one-hot decode, reusable by other units
  - result-record typedef `{logic err; logic [BITS-1:0] vec;}`, parameterised via the package constant
- Sub-module `vr_pipe_stage`: one generic valid/ready register slice, instantiated twice.
- Top level: range check, decode, and the optional counter.

## Test plan
- Reset with `i_rst_n=0` -> `o_valid=0`, `o_result=8'h00`, `o_ready=1`, `o_err_cnt=0`.
- Stream `i_argA`=0..7 with `i_argB=8'hFF` and `i_ready=1` -> results 8'h01, 8'h02 … 8'h80 on consecutive cycles, first 2 cycles after first accept, `o_err=0`.
- `i_argA=8'd8` then `8'd200` -> `o_result=8'h00` and `o_err=1` for both; `o_err_cnt=2` with the macro.
- `i_argA=3`, `i_argB=8'hF7` -> `o_result=8'h00`, `o_err=0`.
- Hold `i_ready=0` and send 3 operands -> `o_ready` drops after the 2nd accept. `o_result` stays stable at the first result. Raising `i_ready` drains both in order.
- Assert `i_rst_n=0` with 2 operands in flight -> `o_valid` goes to 0 asynchronously. No stale result appears after release.
